// File: rtl/alu_seq_pkg.sv
// Shared types for the handshaked sequential ALU: operation codes, FSM states,
// flag payload and small decode helpers.
package alu_seq_pkg;

  localparam int unsigned CTRL_W = 4;

  typedef enum logic [CTRL_W-1:0] {
    ALU_AND   = 4'd0,
    ALU_OR    = 4'd1,
    ALU_XOR   = 4'd2,
    ALU_SLL   = 4'd3,
    ALU_SRL   = 4'd4,
    ALU_SRA   = 4'd5,
    ALU_ADD   = 4'd6,
    ALU_SUB   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_MUL   = 4'd10,
    ALU_MULHU = 4'd11
  } alu_control_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } alu_seq_state_t;

  typedef struct packed {
    logic overflow;
    logic zero;
    logic equal;
  } alu_flags_t;

  function automatic logic is_mul_op(input alu_control_t c);
    return (c == ALU_MUL) || (c == ALU_MULHU);
  endfunction

  function automatic string alu_control_name(input alu_control_t c);
    case (c)
      ALU_AND:   return "AND";
      ALU_OR:    return "OR";
      ALU_XOR:   return "XOR";
      ALU_SLL:   return "SLL";
      ALU_SRL:   return "SRL";
      ALU_SRA:   return "SRA";
      ALU_ADD:   return "ADD";
      ALU_SUB:   return "SUB";
      ALU_SLT:   return "SLT";
      ALU_SLTU:  return "SLTU";
      ALU_MUL:   return "MUL";
      ALU_MULHU: return "MULHU";
      default:   return "INVALID";
    endcase
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier retiring RADIX_BITS multiplier bits per cycle.
// done_o rises the cycle after the final step and holds until the next start.
module alu_mul_iter #(
  parameter int unsigned N          = 32,
  parameter int unsigned RADIX_BITS = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           done_o,
  output logic [2*N-1:0] product_o
);

  localparam int unsigned STEPS = N / RADIX_BITS;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);
  localparam int unsigned PW    = N + RADIX_BITS;

  logic [N-1:0]   a_q, a_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [PW-1:0]  partial;
  logic [PW-1:0]  upper_sum;

  // Multiplier sits in the low half of acc and is consumed as the sum shifts in from the top.
  always_comb begin
    partial   = PW'(a_q) * PW'(acc_q[RADIX_BITS-1:0]);
    upper_sum = PW'(acc_q[2*N-1:N]) + partial;
    a_d       = a_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    if (start_i) begin
      a_d    = a_i;
      acc_d  = {N'(0), b_i};
      cnt_d  = '0;
      busy_d = 1'b1;
      done_d = 1'b0;
    end else if (busy_q) begin
      acc_d = (2*N)'({upper_sum, acc_q[N-1:0]} >> RADIX_BITS);
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(STEPS - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Registered valid/ready ALU: single-cycle logic/arith ops plus iterative MUL/MULHU.
// Result and flags are held in registers until the consumer accepts them.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned N          = 32,
  parameter int unsigned RADIX_BITS = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  alu_control_t control,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         overflow,
  output logic         zero,
  output logic         equal
);

  localparam int unsigned SHW = $clog2(N);

  alu_seq_state_t state_q, state_d;
  logic [N-1:0]   result_q, result_d;
  alu_flags_t     flags_q, flags_d;
  logic           mul_hi_q, mul_hi_d;
  logic           mul_eq_q, mul_eq_d;

  logic           mul_start;
  logic           mul_done;
  logic [2*N-1:0] mul_product;
  logic [N-1:0]   mul_sel;

  logic [SHW-1:0] shamt;
  logic [N-1:0]   sum, diff, alu_res;
  logic           alu_ovf, alu_ok;
  logic           accept;

  alu_mul_iter #(.N(N), .RADIX_BITS(RADIX_BITS)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start),
    .a_i       (a),
    .b_i       (b),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // Single-cycle datapath; alu_ok drops for MUL codes and unassigned encodings.
  always_comb begin
    shamt   = b[SHW-1:0];
    sum     = a + b;
    diff    = a - b;
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ok  = 1'b1;
    case (control)
      ALU_AND:  alu_res = a & b;
      ALU_OR:   alu_res = a | b;
      ALU_XOR:  alu_res = a ^ b;
      ALU_SLL:  alu_res = a << shamt;
      ALU_SRL:  alu_res = a >> shamt;
      ALU_SRA:  alu_res = N'($signed(a) >>> shamt);
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      ALU_SLT:  alu_res = N'($signed(a) < $signed(b));
      ALU_SLTU: alu_res = N'(a < b);
      default:  alu_ok  = 1'b0;
    endcase
  end

  assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign mul_sel  = mul_hi_q ? mul_product[2*N-1:N] : mul_product[N-1:0];

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
    mul_hi_d  = mul_hi_q;
    mul_eq_d  = mul_eq_q;
    mul_start = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
        if (accept) begin
          if (is_mul_op(control)) begin
            state_d   = S_BUSY;
            mul_start = 1'b1;
            mul_hi_d  = (control == ALU_MULHU);
            mul_eq_d  = (a == b);
          end else begin
            state_d          = S_DONE;
            result_d         = alu_res;
            flags_d.overflow = alu_ovf;
            flags_d.zero     = alu_ok && (alu_res == '0);
            flags_d.equal    = alu_ok && (a == b);
          end
        end
      end
      S_BUSY: begin
        if (mul_done) begin
          state_d          = S_DONE;
          result_d         = mul_sel;
          flags_d.overflow = 1'b0;
          flags_d.zero     = (mul_sel == '0);
          flags_d.equal    = mul_eq_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      mul_hi_q <= 1'b0;
      mul_eq_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      mul_hi_q <= mul_hi_d;
      mul_eq_q <= mul_eq_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign overflow  = flags_q.overflow;
  assign zero      = flags_q.zero;
  assign equal     = flags_q.equal;

endmodule
